// File: rtl/issue_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// issue_pkg
//   Shared configuration, lane record and tag-age helper for the issue
//   select controller.
//   Revision: 1.0
// ---------------------------------------------------------------------------
package issue_pkg;

  localparam int NUM_SLOTS_CFG   = 8;
  localparam int NUM_FU_CFG      = 4;
  localparam int TAG_W           = 8;
  localparam int ISSUE_WIDTH_CFG = 2;
  localparam int LAT_W           = 4;

  localparam int SLOT_IDX_W = $clog2(NUM_SLOTS_CFG);
  localparam int FU_IDX_W   = $clog2(NUM_FU_CFG);

  // One issue lane: grant flag plus the slot, FU and tag it carries.
  typedef struct packed {
    logic                  valid;
    logic [SLOT_IDX_W-1:0] slot;
    logic [FU_IDX_W-1:0]   fu;
    logic [TAG_W-1:0]      tag;
  } issue_lane_t;

  // Distance from the ROB head; modulo arithmetic makes wrapped tags
  // compare correctly.
  function automatic logic [TAG_W-1:0] tag_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] head);
    return tag - head;
  endfunction

endpackage
`default_nettype wire

// File: rtl/age_oldest_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// age_oldest_pick
//   Combinational search for the oldest (smallest age) entry under a mask.
//   Ties resolve to the lowest index.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module age_oldest_pick #(
  parameter int N     = 8,
  parameter int AGE_W = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]            mask,
  input  logic [N-1:0][AGE_W-1:0] age,
  output logic                    found,
  output logic [IDX_W-1:0]        idx
);

  logic [AGE_W-1:0] best;

  // Linear scan; strict less-than keeps the lower index on equal ages.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && (!found || (age[i] < best))) begin
        found = 1'b1;
        idx   = IDX_W'(i);
        best  = age[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/issue_select_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// issue_select_ctrl
//   Age-ordered multi-issue selector: picks up to ISSUE_WIDTH ready slots,
//   oldest first, pairs them with free FUs in round-robin order and tracks
//   per-FU busy time for unpipelined multi-cycle units.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module issue_select_ctrl
  import issue_pkg::*;
#(
  parameter int NUM_SLOTS   = NUM_SLOTS_CFG,
  parameter int NUM_FU      = NUM_FU_CFG,
  parameter int TAG_WIDTH   = TAG_W,
  parameter int ISSUE_WIDTH = ISSUE_WIDTH_CFG,
  parameter int LAT_WIDTH   = LAT_W
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic [TAG_WIDTH-1:0]                    head_tag,
  input  logic [NUM_SLOTS-1:0]                    slot_ready,
  input  logic [NUM_SLOTS-1:0][TAG_WIDTH-1:0]     slot_tag,
  input  logic [NUM_SLOTS-1:0][LAT_WIDTH-1:0]     slot_lat,
  input  logic [NUM_FU-1:0]                       fu_avail,
  output logic [NUM_SLOTS-1:0]                    slot_clear,
  output logic [ISSUE_WIDTH-1:0]                  issue_valid,
  output logic [ISSUE_WIDTH-1:0][SLOT_IDX_W-1:0]  issue_slot,
  output logic [ISSUE_WIDTH-1:0][FU_IDX_W-1:0]    issue_fu,
  output logic [ISSUE_WIDTH-1:0][TAG_WIDTH-1:0]   issue_tag,
  output logic [NUM_FU-1:0]                       fu_busy
);

  logic [NUM_SLOTS-1:0][TAG_WIDTH-1:0] age;
  logic [NUM_SLOTS-1:0]                mask [ISSUE_WIDTH+1];
  logic [ISSUE_WIDTH-1:0]              slot_found;
  logic [SLOT_IDX_W-1:0]               pick_idx [ISSUE_WIDTH];

  logic [NUM_FU-1:0]                   free_fu;
  logic [NUM_FU-1:0]                   fu_taken;
  logic [ISSUE_WIDTH-1:0]              fu_found;
  logic [FU_IDX_W-1:0]                 fu_pick [ISSUE_WIDTH];

  issue_lane_t [ISSUE_WIDTH-1:0]       lane_nxt;
  issue_lane_t [ISSUE_WIDTH-1:0]       lane_q;
  logic [NUM_FU-1:0][LAT_WIDTH-1:0]    busy_cnt;
  logic [NUM_FU-1:0][LAT_WIDTH-1:0]    busy_nxt;
  logic [FU_IDX_W-1:0]                 rr_ptr;
  logic [FU_IDX_W-1:0]                 rr_nxt;
  logic                                any_grant;

  // Wrap-aware age of every slot relative to the ROB head.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      age[i] = tag_age(slot_tag[i], head_tag);
    end
  end

  assign mask[0] = slot_ready;

  // Each lane picks the oldest slot left after earlier lanes removed theirs.
  generate
    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_lane
      age_oldest_pick #(
        .N     (NUM_SLOTS),
        .AGE_W (TAG_WIDTH),
        .IDX_W (SLOT_IDX_W)
      ) u_pick (
        .mask  (mask[k]),
        .age   (age),
        .found (slot_found[k]),
        .idx   (pick_idx[k])
      );
      assign mask[k+1] = mask[k] &
                         ~({{(NUM_SLOTS-1){1'b0}}, slot_found[k]} << pick_idx[k]);
    end
  endgenerate

  // An FU is free when enabled and its occupancy counter has drained.
  generate
    for (genvar f = 0; f < NUM_FU; f++) begin : g_free
      assign free_fu[f] = fu_avail[f] & (busy_cnt[f] == '0);
      assign fu_busy[f] = (busy_cnt[f] != '0);
    end
  endgenerate

  // Lane k takes the k-th free FU scanning upward from rr_ptr with wrap.
  always_comb begin
    fu_taken = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      fu_found[k] = 1'b0;
      fu_pick[k]  = '0;
      for (int j = 0; j < NUM_FU; j++) begin
        int f;
        f = int'(rr_ptr) + j;
        if (f >= NUM_FU) f = f - NUM_FU;
        if (!fu_found[k] && free_fu[f] && !fu_taken[f]) begin
          fu_found[k] = 1'b1;
          fu_pick[k]  = FU_IDX_W'(f);
        end
      end
      if (fu_found[k]) fu_taken[fu_pick[k]] = 1'b1;
    end
  end

  // Form grants, slot-clear acks, next busy counts and next rr pointer.
  always_comb begin
    lane_nxt   = '0;
    slot_clear = '0;
    any_grant  = 1'b0;
    rr_nxt     = rr_ptr;
    for (int f = 0; f < NUM_FU; f++) begin
      busy_nxt[f] = (busy_cnt[f] != '0) ? busy_cnt[f] - 1'b1 : '0;
    end
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      if (rst_n && !flush && slot_found[k] && fu_found[k]) begin
        lane_nxt[k].valid = 1'b1;
        lane_nxt[k].slot  = pick_idx[k];
        lane_nxt[k].fu    = fu_pick[k];
        lane_nxt[k].tag   = slot_tag[pick_idx[k]];
        slot_clear[pick_idx[k]] = 1'b1;
        // Latency 0 behaves as 1, which leaves the counter at zero.
        busy_nxt[fu_pick[k]] = (slot_lat[pick_idx[k]] == '0) ? '0
                             : slot_lat[pick_idx[k]] - 1'b1;
        any_grant = 1'b1;
        rr_nxt = (int'(fu_pick[k]) == NUM_FU - 1) ? '0 : fu_pick[k] + 1'b1;
      end
    end
  end

  // Output lanes, busy counters and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q   <= '0;
      busy_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      lane_q   <= lane_nxt;
      busy_cnt <= flush ? '0 : busy_nxt;
      if (any_grant) rr_ptr <= rr_nxt;
    end
  end

  generate
    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_out
      assign issue_valid[k] = lane_q[k].valid;
      assign issue_slot[k]  = lane_q[k].slot;
      assign issue_fu[k]    = lane_q[k].fu;
      assign issue_tag[k]   = lane_q[k].tag;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_issue_select_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_issue_select_ctrl
//   Directed vector table plus hand sequences for multi-cycle behaviour.
//   Revision: 1.0
// ---------------------------------------------------------------------------
module tb_issue_select_ctrl;
  import issue_pkg::*;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           flush;
  logic [7:0]                     head_tag;
  logic [7:0]                     slot_ready;
  logic [7:0][7:0]                slot_tag;
  logic [7:0][3:0]                slot_lat;
  logic [3:0]                     fu_avail;
  logic [7:0]                     slot_clear;
  logic [1:0]                     issue_valid;
  logic [1:0][2:0]                issue_slot;
  logic [1:0][1:0]                issue_fu;
  logic [1:0][7:0]                issue_tag;
  logic [3:0]                     fu_busy;

  int errors = 0;
  int checks = 0;

  issue_select_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .head_tag    (head_tag),
    .slot_ready  (slot_ready),
    .slot_tag    (slot_tag),
    .slot_lat    (slot_lat),
    .fu_avail    (fu_avail),
    .slot_clear  (slot_clear),
    .issue_valid (issue_valid),
    .issue_slot  (issue_slot),
    .issue_fu    (issue_fu),
    .issue_tag   (issue_tag),
    .fu_busy     (fu_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  head;
    logic [7:0]  ready;
    logic [63:0] tags;
    logic [3:0]  avail;
    logic        fl;
    logic [7:0]  clr;
    logic [1:0]  v;
    logic [2:0]  s0;
    logic [1:0]  f0;
    logic [7:0]  t0;
    logic [2:0]  s1;
    logic [1:0]  f1;
    logic [7:0]  t1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] h, input logic [7:0] r, input logic [63:0] t,
                       input logic [31:0] l, input logic [3:0] a, input logic f);
    head_tag   = h;
    slot_ready = r;
    slot_tag   = t;
    slot_lat   = l;
    fu_avail   = a;
    flush      = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 64'h0, 32'h1111_1111, 4'hF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 8'h00, 64'h0, 32'h1111_1111, 4'hF, 1'b0);

    vecs[0] = '{"dual_age", 8'h10, 8'h68, 64'h0018_1200_1400_0000, 4'hF, 1'b0, 8'h28,
                2'b11, 3'd5, 2'd0, 8'h12, 3'd3, 2'd1, 8'h14};
    vecs[1] = '{"fu_limited", 8'h00, 8'h0F, 64'h0000_0000_0407_0305, 4'b0100, 1'b0, 8'h02,
                2'b01, 3'd1, 2'd2, 8'h03, 3'd0, 2'd0, 8'h00};
    vecs[2] = '{"tie_low_idx", 8'h00, 8'h54, 64'h0009_000A_0009_0000, 4'hF, 1'b0, 8'h44,
                2'b11, 3'd2, 2'd0, 8'h09, 3'd6, 2'd1, 8'h09};
    vecs[3] = '{"none_ready", 8'h00, 8'h00, 64'h0102_0304_0506_0708, 4'hF, 1'b0, 8'h00,
                2'b00, 3'd0, 2'd0, 8'h00, 3'd0, 2'd0, 8'h00};
    vecs[4] = '{"no_fu", 8'h00, 8'hFF, 64'h0102_0304_0506_0708, 4'h0, 1'b0, 8'h00,
                2'b00, 3'd0, 2'd0, 8'h00, 3'd0, 2'd0, 8'h00};
    vecs[5] = '{"flush", 8'h10, 8'h68, 64'h0018_1200_1400_0000, 4'hF, 1'b1, 8'h00,
                2'b00, 3'd0, 2'd0, 8'h00, 3'd0, 2'd0, 8'h00};
    vecs[6] = '{"wrap_dual", 8'hF0, 8'h03, 64'h0000_0000_0000_F802, 4'hF, 1'b0, 8'h03,
                2'b11, 3'd1, 2'd0, 8'hF8, 3'd0, 2'd1, 8'h02};
    vecs[7] = '{"sparse_fu", 8'h20, 8'h81, 64'h2000_0000_0000_0021, 4'b1010, 1'b0, 8'h81,
                2'b11, 3'd7, 2'd1, 8'h20, 3'd0, 2'd3, 8'h21};

    // Reset then idle
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_clear", 64'(slot_clear), 64'h0);
    check("rst_valid", 64'(issue_valid), 64'h0);
    check("rst_slot", 64'(issue_slot), 64'h0);
    check("rst_fu", 64'(issue_fu), 64'h0);
    check("rst_tag", 64'(issue_tag), 64'h0);
    check("rst_busy", 64'(fu_busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_valid", 64'(issue_valid), 64'h0);
    check("idle_busy", 64'(fu_busy), 64'h0);
    check("idle_clear", 64'(slot_clear), 64'h0);

    // Vector table, each from a fresh reset so rr_ptr starts at 0
    for (int i = 0; i < 8; i++) begin
      do_reset();
      drive(vecs[i].head, vecs[i].ready, vecs[i].tags, 32'h1111_1111, vecs[i].avail, vecs[i].fl);
      #1;
      check({vecs[i].name, "_clear"}, 64'(slot_clear), 64'(vecs[i].clr));
      @(posedge clk);
      #1;
      check({vecs[i].name, "_valid"}, 64'(issue_valid), 64'(vecs[i].v));
      check({vecs[i].name, "_s0"}, 64'(issue_slot[0]), 64'(vecs[i].s0));
      check({vecs[i].name, "_f0"}, 64'(issue_fu[0]), 64'(vecs[i].f0));
      check({vecs[i].name, "_t0"}, 64'(issue_tag[0]), 64'(vecs[i].t0));
      check({vecs[i].name, "_s1"}, 64'(issue_slot[1]), 64'(vecs[i].s1));
      check({vecs[i].name, "_f1"}, 64'(issue_fu[1]), 64'(vecs[i].f1));
      check({vecs[i].name, "_t1"}, 64'(issue_tag[1]), 64'(vecs[i].t1));
      check({vecs[i].name, "_busy"}, 64'(fu_busy), 64'h0);
    end

    // Round-robin pointer advances past the last granted FU and wraps
    do_reset();
    drive(8'h10, 8'h68, 64'h0018_1200_1400_0000, 32'h1111_1111, 4'hF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8'h10, 8'h01, 64'h11, 32'h1111_1111, 4'hF, 1'b0);
    @(posedge clk);
    #1;
    check("rr_fu2", 64'(issue_fu[0]), 64'd2);
    check("rr_single", 64'(issue_valid), 64'b01);
    @(posedge clk);
    #1;
    check("rr_fu3", 64'(issue_fu[0]), 64'd3);
    @(posedge clk);
    #1;
    check("rr_wrap_fu0", 64'(issue_fu[0]), 64'd0);

    // Wrap-around age with one FU: older wrapped tag goes first
    do_reset();
    drive(8'hF0, 8'h03, 64'hF802, 32'h1111_1111, 4'b0001, 1'b0);
    #1;
    check("wrap1_clear", 64'(slot_clear), 64'h02);
    @(posedge clk);
    #1;
    check("wrap1_slot", 64'(issue_slot[0]), 64'd1);
    check("wrap1_tag", 64'(issue_tag[0]), 64'hF8);
    @(negedge clk);
    slot_ready = 8'h01;
    #1;
    check("wrap2_clear", 64'(slot_clear), 64'h01);
    @(posedge clk);
    #1;
    check("wrap2_valid", 64'(issue_valid), 64'b01);
    check("wrap2_slot", 64'(issue_slot[0]), 64'd0);
    check("wrap2_tag", 64'(issue_tag[0]), 64'h02);

    // Multi-cycle FU: lat=3 keeps FU0 busy for two cycles
    do_reset();
    drive(8'h00, 8'h01, 64'h01, 32'h0000_0003, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    check("mc_grant", 64'(issue_valid), 64'b01);
    check("mc_busy_e0", 64'(fu_busy), 64'b0001);
    @(negedge clk);
    drive(8'h00, 8'h01, 64'h02, 32'h0000_0001, 4'b0001, 1'b0);
    #1;
    check("mc_clear_e0", 64'(slot_clear), 64'h0);
    @(posedge clk);
    #1;
    check("mc_valid_e1", 64'(issue_valid), 64'b00);
    check("mc_busy_e1", 64'(fu_busy), 64'b0001);
    @(negedge clk);
    check("mc_clear_e1", 64'(slot_clear), 64'h0);
    @(posedge clk);
    #1;
    check("mc_valid_e2", 64'(issue_valid), 64'b00);
    check("mc_busy_e2", 64'(fu_busy), 64'b0000);
    @(negedge clk);
    check("mc_clear_e2", 64'(slot_clear), 64'h01);
    @(posedge clk);
    #1;
    check("mc_valid_e3", 64'(issue_valid), 64'b01);
    check("mc_tag_e3", 64'(issue_tag[0]), 64'h02);

    // Flush with a busy counter active; rr_ptr must hold across it
    do_reset();
    drive(8'h00, 8'h01, 64'h01, 32'h0000_0006, 4'b0010, 1'b0);
    @(posedge clk);
    #1;
    check("fl_busy_pre", 64'(fu_busy), 64'b0010);
    @(negedge clk);
    drive(8'h10, 8'h68, 64'h0018_1200_1400_0000, 32'h1111_1111, 4'hF, 1'b1);
    #1;
    check("fl_clear", 64'(slot_clear), 64'h0);
    @(posedge clk);
    #1;
    check("fl_valid", 64'(issue_valid), 64'b00);
    check("fl_busy", 64'(fu_busy), 64'b0000);
    @(negedge clk);
    drive(8'h00, 8'h01, 64'h01, 32'h1111_1111, 4'hF, 1'b0);
    @(posedge clk);
    #1;
    check("fl_rr_hold", 64'(issue_fu[0]), 64'd2);

    // Reset mid-operation clears busy counters and gates slot_clear
    do_reset();
    drive(8'h00, 8'h01, 64'h01, 32'h0000_0008, 4'b0001, 1'b0);
    @(posedge clk);
    #1;
    check("mr_busy_pre", 64'(fu_busy), 64'b0001);
    @(negedge clk);
    rst_n = 1'b0;
    drive(8'h00, 8'h01, 64'h01, 32'h1111_1111, 4'hF, 1'b0);
    #1;
    check("mr_clear", 64'(slot_clear), 64'h0);
    @(posedge clk);
    #1;
    check("mr_busy", 64'(fu_busy), 64'b0000);
    check("mr_valid", 64'(issue_valid), 64'b00);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
